// File: rtl/pulse_train_controller_pkg.sv
// Shared types and helpers for the pulse train controller.
// Holds the sequencer state encoding and the phase-counter reload rule.
package pulse_train_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pulse_train_controller_state_t;

    // A programmed length of 0 behaves as 1, so the counter reload floors at 0.
    localparam int unsigned MIN_PHASE_CYCLES = 1;

    function automatic logic [31:0] phase_reload(input logic [31:0] cfg);
        return (cfg < MIN_PHASE_CYCLES) ? 32'd0 : cfg - MIN_PHASE_CYCLES;
    endfunction

endpackage

// File: rtl/pulse_train_controller_phase_counter.sv
// Loadable, non-wrapping down-counter with a zero flag.
// Times one phase (high or low) of the pulse train.
module phase_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_train_controller.sv
// Generates N pulses of W high cycles separated by G low cycles, launched by start.
// Build option PULSE_TRAIN_CONTROLLER_CONTINUOUS_EN: cfg_count=0 repeats pulses until abort.
module pulse_train_controller
    import pulse_train_controller_pkg::*;
#(
    parameter int WIDTH_WIDTH = 8,
    parameter int GAP_WIDTH   = 8,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [WIDTH_WIDTH-1:0] cfg_width,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    output logic                   pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pulse_index
);

    pulse_train_controller_state_t state, next_state;

    logic [WIDTH_WIDTH-1:0] width_sh;
    logic [GAP_WIDTH-1:0]   gap_sh;
    logic [COUNT_WIDTH-1:0] count_sh;

    logic                   accept;
    logic                   launch_ok;
    logic                   last_pulse;
    logic                   capture;
    logic                   w_load;
    logic                   g_load;
    logic                   w_zero;
    logic                   g_zero;
    logic                   done_next;
    logic [COUNT_WIDTH-1:0] idx_next;
    logic [WIDTH_WIDTH-1:0] w_load_value;
    logic [GAP_WIDTH-1:0]   g_load_value;

    // The done cycle is IDLE too, but a start there must still be ignored.
    assign accept = (state == ST_IDLE) && start && !abort && !done;

`ifdef PULSE_TRAIN_CONTROLLER_CONTINUOUS_EN
    assign launch_ok  = 1'b1;
    assign last_pulse = (count_sh != '0) && (pulse_index == count_sh - COUNT_WIDTH'(1));
`else
    assign launch_ok  = (cfg_count != '0);
    assign last_pulse = (pulse_index == count_sh - COUNT_WIDTH'(1));
`endif

    // On launch the shadows are loading in the same edge, so reload from the live config.
    assign w_load_value = (state == ST_IDLE) ? WIDTH_WIDTH'(phase_reload(32'(cfg_width)))
                                             : WIDTH_WIDTH'(phase_reload(32'(width_sh)));
    assign g_load_value = GAP_WIDTH'(phase_reload(32'(gap_sh)));

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        w_load     = 1'b0;
        g_load     = 1'b0;
        done_next  = 1'b0;
        idx_next   = pulse_index;
        case (state)
            ST_IDLE: begin
                idx_next = '0;
                if (accept) begin
                    if (launch_ok) begin
                        next_state = ST_HIGH;
                        capture    = 1'b1;
                        w_load     = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    next_state = ST_IDLE;
                    idx_next   = '0;
                end else if (w_zero) begin
                    if (last_pulse) begin
                        next_state = ST_IDLE;
                        done_next  = 1'b1;
                        idx_next   = '0;
                    end else begin
                        next_state = ST_LOW;
                        g_load     = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (abort) begin
                    next_state = ST_IDLE;
                    idx_next   = '0;
                end else if (g_zero) begin
                    next_state = ST_HIGH;
                    w_load     = 1'b1;
                    idx_next   = pulse_index + COUNT_WIDTH'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_index <= '0;
            width_sh    <= '0;
            gap_sh      <= '0;
            count_sh    <= '0;
        end else begin
            state       <= next_state;
            pulse_out   <= (next_state == ST_HIGH);
            busy        <= (next_state != ST_IDLE);
            done        <= done_next;
            pulse_index <= idx_next;
            if (capture) begin
                width_sh <= cfg_width;
                gap_sh   <= cfg_gap;
                count_sh <= cfg_count;
            end
        end
    end

    phase_counter #(.WIDTH(WIDTH_WIDTH)) u_high_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (w_load),
        .dec        (state == ST_HIGH),
        .load_value (w_load_value),
        .zero       (w_zero)
    );

    phase_counter #(.WIDTH(GAP_WIDTH)) u_low_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (g_load),
        .dec        (state == ST_LOW),
        .load_value (g_load_value),
        .zero       (g_zero)
    );

endmodule

// File: tb/tb_pulse_train_controller.sv
// Self-checking bench for pulse_train_controller: per-cycle waveform model plus literal pins.
// Cycle c is the interval ending at edge c; inputs held in cycle c are sampled at edge c.
module tb_pulse_train_controller;

    localparam int MAXC = 700;
`ifdef PULSE_TRAIN_CONTROLLER_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_width = '0;
    logic [7:0] cfg_gap = '0;
    logic [7:0] cfg_count = '0;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] pulse_index;

    int checks = 0;
    int failures = 0;

    int exp_p [0:MAXC];
    int exp_b [0:MAXC];
    int exp_d [0:MAXC];
    int exp_i [0:MAXC];

    pulse_train_controller dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .cfg_width   (cfg_width),
        .cfg_gap     (cfg_gap),
        .cfg_count   (cfg_count),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulse_index (pulse_index)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int cyc, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, expv);
        end
    endtask

    // Expected waveform from the train rules: segments of W high and G low, done after last high.
    task automatic build_model(input int w, input int g, input int n, input int cut, input int len);
        int we, ge, t, p;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        for (int c = 0; c <= len; c++) begin
            exp_p[c] = 0; exp_b[c] = 0; exp_d[c] = 0; exp_i[c] = 0;
        end
        t = 1;
        p = 0;
        if (n == 0 && !CONT) begin
            exp_d[1] = 1;
        end else begin
            while (t <= len) begin
                for (int j = 0; j < we && t <= len; j++) begin
                    exp_p[t] = 1; exp_b[t] = 1; exp_i[t] = p % 256;
                    t++;
                end
                if (n != 0 && p == n - 1) begin
                    if (t <= len) exp_d[t] = 1;
                    break;
                end
                for (int j = 0; j < ge && t <= len; j++) begin
                    exp_b[t] = 1; exp_i[t] = p % 256;
                    t++;
                end
                p++;
            end
        end
        if (cut >= 0) begin
            for (int c = cut + 1; c <= len; c++) begin
                exp_p[c] = 0; exp_b[c] = 0; exp_d[c] = 0; exp_i[c] = 0;
            end
        end
    endtask

    // Launch at edge 0, then compare all outputs against the model after every edge.
    task automatic drive(input int w, input int g, input int n, input int abort_c,
                         input int reset_c, input int restart_c, input bit jitter, input int len);
        for (int c = 0; c < len; c++) begin
            start = (c == 0) || (c == restart_c);
            abort = (c == abort_c);
            reset = (c == reset_c);
            if (c == 0) begin
                cfg_width = 8'(w); cfg_gap = 8'(g); cfg_count = 8'(n);
            end else if (jitter) begin
                cfg_width = 8'd7; cfg_gap = 8'd5; cfg_count = 8'd9;
            end
            @(posedge clock);
            #1;
            check("pulse_out", c + 1, int'(pulse_out), exp_p[c + 1]);
            check("busy", c + 1, int'(busy), exp_b[c + 1]);
            check("done", c + 1, int'(done), exp_d[c + 1]);
            check("pulse_index", c + 1, int'(pulse_index), exp_i[c + 1]);
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
    endtask

    task automatic pin_basic();
        check("pin_b_p1", 1, exp_p[1], 1);
        check("pin_b_p3", 3, exp_p[3], 1);
        check("pin_b_p4", 4, exp_p[4], 0);
        check("pin_b_p5", 5, exp_p[5], 0);
        check("pin_b_p6", 6, exp_p[6], 1);
        check("pin_b_p9", 9, exp_p[9], 0);
        check("pin_b_b8", 8, exp_b[8], 1);
        check("pin_b_b9", 9, exp_b[9], 0);
        check("pin_b_d8", 8, exp_d[8], 0);
        check("pin_b_d9", 9, exp_d[9], 1);
        check("pin_b_i6", 6, exp_i[6], 1);
    endtask

    initial begin
        // Reset overrides a concurrent start.
        start = 1'b1;
        cfg_width = 8'd3; cfg_gap = 8'd2; cfg_count = 8'd2;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("rst_pulse_out", k, int'(pulse_out), 0);
            check("rst_busy", k, int'(busy), 0);
            check("rst_done", k, int'(done), 0);
            check("rst_index", k, int'(pulse_index), 0);
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;

        build_model(3, 2, 2, -1, 12);
        pin_basic();
        drive(3, 2, 2, -1, -1, -1, 1'b0, 12);

        build_model(0, 0, 3, -1, 9);
        check("pin_z_p1", 1, exp_p[1], 1);
        check("pin_z_p2", 2, exp_p[2], 0);
        check("pin_z_p5", 5, exp_p[5], 1);
        check("pin_z_d6", 6, exp_d[6], 1);
        drive(0, 0, 3, -1, -1, -1, 1'b0, 9);

        build_model(4, 4, 5, 6, 20);
        check("pin_a_b6", 6, exp_b[6], 1);
        check("pin_a_b7", 7, exp_b[7], 0);
        check("pin_a_i7", 7, exp_i[7], 0);
        drive(4, 4, 5, 6, -1, -1, 1'b0, 20);

        // Restart and config changes during the train must not disturb it.
        build_model(3, 2, 2, -1, 12);
        pin_basic();
        drive(3, 2, 2, -1, -1, 3, 1'b1, 12);

        // Start in the done cycle is ignored.
        build_model(1, 1, 1, -1, 6);
        check("pin_dc_d2", 2, exp_d[2], 1);
        check("pin_dc_p3", 3, exp_p[3], 0);
        drive(1, 1, 1, -1, -1, 2, 1'b0, 6);

        // Abort together with start in IDLE wins.
        build_model(2, 2, 2, 0, 5);
        drive(2, 2, 2, 0, -1, -1, 1'b0, 5);

        // Reset together with start.
        build_model(2, 2, 2, 0, 5);
        drive(2, 2, 2, -1, 0, -1, 1'b0, 5);

        build_model(5, 2, 2, 2, 10);
        check("pin_r_p2", 2, exp_p[2], 1);
        check("pin_r_p3", 3, exp_p[3], 0);
        drive(5, 2, 2, -1, 2, -1, 1'b0, 10);

        build_model(3, 2, 2, -1, 12);
        drive(3, 2, 2, -1, -1, -1, 1'b0, 12);

`ifdef PULSE_TRAIN_CONTROLLER_CONTINUOUS_EN
        build_model(1, 1, 0, 600, 610);
        check("pin_c_i511", 511, exp_i[511], 255);
        check("pin_c_i513", 513, exp_i[513], 0);
        check("pin_c_p599", 599, exp_p[599], 1);
        check("pin_c_b601", 601, exp_b[601], 0);
        drive(1, 1, 0, 600, -1, -1, 1'b0, 610);
`else
        build_model(3, 2, 0, -1, 4);
        check("pin_n0_d1", 1, exp_d[1], 1);
        check("pin_n0_b1", 1, exp_b[1], 0);
        check("pin_n0_d2", 2, exp_d[2], 0);
        drive(3, 2, 0, -1, -1, -1, 1'b0, 4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
